// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code tracker: parses make/break/extended sequences,
// keeps a held-key bitmap and count, and queues key events in a FIFO.
//
// Ports:
//   clk, rst (async active-low)
//   byte_in/byte_valid/byte_err : bytes and error strobes from the PS/2 receiver
//   key_down[511:0], key_count  : held-key bitmap indexed by {ext,code}, popcount
//   ev_data/ev_valid/ev_ready   : first-word-fall-through event FIFO {rpt,brk,ext,code}
//   ovf/ovf_clr                 : sticky event-drop flag and its clear
//
// Optional feature: define KEY_REPEAT_EVT_EN to queue typematic repeat
// events (rpt=1) when a make arrives for a key that is already held.
module ps2_key_tracker #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 2000000,
    parameter bit WAIT_BAT    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    input  logic         byte_err,
    output logic [511:0] key_down,
    output logic [9:0]   key_count,
    output logic [10:0]  ev_data,
    output logic         ev_valid,
    input  logic         ev_ready,
    output logic         ovf,
    input  logic         ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_SKIP
    } state_t;

    localparam state_t RST_ST = WAIT_BAT ? S_INIT : S_IDLE;

    state_t        st, st_nxt;
    logic [2:0]    skip_cnt, skip_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;

    logic do_make, do_brk, do_bat, ext;

    // Parser: next state, prefix tracking and timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= RST_ST;
            skip_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            st       <= st_nxt;
            skip_cnt <= skip_nxt;
            tmo_cnt  <= tmo_nxt;
        end
    end

    always_comb begin
        st_nxt   = st;
        skip_nxt = skip_cnt;
        tmo_nxt  = '0;
        do_make  = 1'b0;
        do_brk   = 1'b0;
        do_bat   = 1'b0;
        ext      = 1'b0;
        if (byte_err && st != S_INIT) begin
            st_nxt = S_IDLE;
        end else if (byte_valid) begin
            unique case (st)
                S_INIT: begin
                    if (byte_in == 8'hAA) st_nxt = S_IDLE;
                end
                S_IDLE: begin
                    unique case (byte_in)
                        8'hE0: st_nxt = S_EXT;
                        8'hF0: st_nxt = S_BRK;
                        8'hE1: begin
                            st_nxt   = S_SKIP;
                            skip_nxt = '0;
                        end
                        8'hAA: do_bat = 1'b1;
                        default: do_make = 1'b1;
                    endcase
                end
                S_EXT: begin
                    if (byte_in == 8'hF0) begin
                        st_nxt = S_EXT_BRK;
                    end else if (byte_in != 8'hE0) begin
                        do_make = 1'b1;
                        ext     = 1'b1;
                        st_nxt  = S_IDLE;
                    end
                end
                S_BRK: begin
                    do_brk = 1'b1;
                    st_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    do_brk = 1'b1;
                    ext    = 1'b1;
                    st_nxt = S_IDLE;
                end
                S_SKIP: begin
                    // Pause is E1 followed by seven more bytes
                    if (skip_cnt == 3'd6) st_nxt = S_IDLE;
                    else skip_nxt = skip_cnt + 3'd1;
                end
                default: st_nxt = RST_ST;
            endcase
        end else if (st inside {S_EXT, S_BRK, S_EXT_BRK, S_SKIP}) begin
            if (tmo_cnt == TMO_LAST) st_nxt = S_IDLE;
            else tmo_nxt = tmo_cnt + 1'b1;
        end
    end

    // Key bitmap and event generation
    logic [8:0]  code;
    logic        is_down;
    logic        push, inc, dec;
    logic [10:0] push_data;

    assign code    = {ext, byte_in};
    assign is_down = key_down[code];

    always_comb begin
        push      = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        push_data = '0;
        if (do_make) begin
            if (!is_down) begin
                push      = 1'b1;
                inc       = 1'b1;
                push_data = {2'b00, code};
            end
`ifdef KEY_REPEAT_EVT_EN
            else begin
                push      = 1'b1;
                push_data = {2'b10, code};
            end
`endif
        end else if (do_brk && is_down) begin
            push      = 1'b1;
            dec       = 1'b1;
            push_data = {2'b01, code};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_down  <= '0;
            key_count <= '0;
        end else if (do_bat) begin
            key_down  <= '0;
            key_count <= '0;
        end else if (inc) begin
            key_down[code] <= 1'b1;
            key_count      <= key_count + 10'd1;
        end else if (dec) begin
            key_down[code] <= 1'b0;
            key_count      <= key_count - 10'd1;
        end
    end

    // Event FIFO, first-word fall-through
    logic [10:0] mem [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    logic        full, empty, pop, wr_en, drop;
    logic [10:0] last_q;

    assign empty    = (wp == rp);
    assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign ev_valid = !empty;
    assign pop      = ev_valid && ev_ready;
    assign wr_en    = push && (!full || pop);
    assign drop     = push && full && !pop;
    // Keep showing the last head once the FIFO drains
    assign ev_data  = ev_valid ? mem[rp[AW-1:0]] : last_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp     <= '0;
            rp     <= '0;
            last_q <= '0;
            ovf    <= 1'b0;
        end else begin
            last_q <= ev_data;
            if (wr_en) wp <= wp + 1'b1;
            if (pop)   rp <= rp + 1'b1;
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed self-checking bench for ps2_key_tracker.
// Runs with FIFO_DEPTH=8 and a short timeout.
module tb_ps2_key_tracker;

    localparam int TMO = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_err;
    logic [511:0] key_down;
    logic [9:0]   key_count;
    logic [10:0]  ev_data;
    logic         ev_valid;
    logic         ev_ready;
    logic         ovf;
    logic         ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_key_tracker #(
        .FIFO_DEPTH (8),
        .TIMEOUT_CYC(TMO),
        .WAIT_BAT   (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_err  (byte_err),
        .key_down  (key_down),
        .key_count (key_count),
        .ev_data   (ev_data),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_err();
        @(negedge clk);
        byte_err = 1'b1;
        @(negedge clk);
        byte_err = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [10:0] exp);
        chk({tag, "_v"}, {31'd0, ev_valid}, 32'd1);
        chk({tag, "_d"}, {21'd0, ev_data}, {21'd0, exp});
        pop();
    endtask

    initial begin
        logic [10:0] exp_q [8];
        exp_q = '{11'h015, 11'h01D, 11'h024, 11'h02D,
                  11'h02C, 11'h035, 11'h03C, 11'h043};
        rst        = 1'b0;
        byte_in    = '0;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        ev_ready   = 1'b0;
        ovf_clr    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_data", {21'd0, ev_data}, 32'd0);
        chk("rst_cnt", {22'd0, key_count}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_kd", {31'd0, key_down == '0}, 32'd1);
        rst = 1'b1;

        send(8'h1C);
        chk("init_ign_cnt", {22'd0, key_count}, 32'd0);
        chk("init_ign_v", {31'd0, ev_valid}, 32'd0);

        send(8'hAA);
        send(8'h1C);
        chk("mk1c_kd", {31'd0, key_down[9'h01C]}, 32'd1);
        chk("mk1c_cnt", {22'd0, key_count}, 32'd1);
        pop_chk("mk1c", 11'h01C);
        chk("hold_v", {31'd0, ev_valid}, 32'd0);
        chk("hold_d", {21'd0, ev_data}, 32'h01C);

        send(8'hE0);
        send(8'h75);
        chk("mk175_kd", {31'd0, key_down[9'h175]}, 32'd1);
        chk("mk175_cnt", {22'd0, key_count}, 32'd2);
        pop_chk("mk175", 11'h175);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("br175_kd", {31'd0, key_down[9'h175]}, 32'd0);
        chk("br175_cnt", {22'd0, key_count}, 32'd1);
        pop_chk("br175", 11'h375);

        send(8'h1C);
        send(8'h1C);
        chk("rpt_cnt", {22'd0, key_count}, 32'd1);
`ifdef KEY_REPEAT_EVT_EN
        pop_chk("rpt1", 11'h41C);
        pop_chk("rpt2", 11'h41C);
`endif
        chk("rpt_empty", {31'd0, ev_valid}, 32'd0);

        send(8'hF0);
        send(8'h1C);
        chk("br1c_cnt", {22'd0, key_count}, 32'd0);
        pop_chk("br1c", 11'h21C);

        send(8'h15);
        send(8'h1D);
        send(8'h24);
        send(8'h2D);
        send(8'h2C);
        send(8'h35);
        send(8'h3C);
        send(8'h43);
        chk("full_noovf", {31'd0, ovf}, 32'd0);
        send(8'h44);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        chk("ovf_cnt", {22'd0, key_count}, 32'd9);
        chk("ovf_kd44", {31'd0, key_down[9'h044]}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            pop_chk($sformatf("fifo%0d", i), exp_q[i]);
        end
        chk("drained", {31'd0, ev_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", {31'd0, ovf}, 32'd0);

        send(8'hAA);
        chk("bat_cnt", {22'd0, key_count}, 32'd0);
        chk("bat_kd", {31'd0, key_down == '0}, 32'd1);
        chk("bat_noev", {31'd0, ev_valid}, 32'd0);

        send(8'hF0);
        repeat (TMO + 2) @(negedge clk);
        send(8'h1C);
        chk("tmo_cnt", {22'd0, key_count}, 32'd1);
        pop_chk("tmo", 11'h01C);

        send(8'hE1);
        send(8'h14);
        send(8'h77);
        send(8'hE1);
        send(8'hF0);
        send(8'h14);
        send(8'hF0);
        send(8'h77);
        chk("pause_cnt", {22'd0, key_count}, 32'd1);
        chk("pause_noev", {31'd0, ev_valid}, 32'd0);
        chk("pause_kd14", {31'd0, key_down[9'h014]}, 32'd0);
        send(8'h1D);
        chk("post_pause_cnt", {22'd0, key_count}, 32'd2);
        pop_chk("post_pause", 11'h01D);

        send(8'hE0);
        send_err();
        send(8'h75);
        chk("err_kd075", {31'd0, key_down[9'h075]}, 32'd1);
        chk("err_kd175", {31'd0, key_down[9'h175]}, 32'd0);
        pop_chk("err", 11'h075);

        send(8'hAA);
        chk("bat2_cnt", {22'd0, key_count}, 32'd0);
        chk("bat2_kd", {31'd0, key_down == '0}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth (power of 2, 2..64).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2000000, idle cycles before a partial sequence is discarded.
REQ-003 SHALL have parameter WAIT_BAT, default 1; 1 = start in INIT awaiting 8'hAA, 0 = start in IDLE.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port byte_in, input, 8, received PS/2 scan-code byte.
REQ-007 SHALL have port byte_valid, input, 1, one-cycle strobe qualifying byte_in.
REQ-008 SHALL have port byte_err, input, 1, one-cycle strobe: receiver framing/parity error.
REQ-009 SHALL have port key_down, output, 512, bit {ext,code} high while that key is held.
REQ-010 SHALL have port key_count, output, 10, number of set bits in key_down.
REQ-011 SHALL have port ev_data, output, 11, FIFO head {rpt, brk, ext, code[7:0]}.
REQ-012 SHALL have port ev_valid, output, 1, FIFO non-empty.
REQ-013 SHALL have port ev_ready, input, 1, consumer pop; pop occurs when ev_valid && ev_ready.
REQ-014 SHALL have port ovf, output, 1, sticky event-drop flag.
REQ-015 SHALL have port ovf_clr, input, 1, clears ovf.

Function
REQ-016 SHALL implement parser states INIT, IDLE, EXT, BRK, EXT_BRK, SKIP.
REQ-017 SHALL act only on byte_valid; byte_in ignored otherwise.
REQ-018 INIT: 8'hAA -> IDLE; all other bytes ignored.
REQ-019 IDLE: E0 -> EXT; F0 -> BRK; E1 -> SKIP; AA -> BAT clear (REQ-025); other -> make of {0,byte}, stay IDLE.
REQ-020 EXT: F0 -> EXT_BRK; E0 stays EXT; other -> make of {1,byte}, IDLE.
REQ-021 BRK: byte -> break of {0,byte}, IDLE; EXT_BRK: byte -> break of {1,byte}, IDLE.
REQ-022 SKIP: discard exactly 7 further bytes (Pause tail), then IDLE; no key_down or event change.
REQ-023 Make of key not down: set bit, key_count+1, push {0,0,ext,code}; break of key down: clear bit, key_count-1, push {0,1,ext,code}.
REQ-024 Make of key already down or break of key not down: no key_down/key_count change, no push (except REQ-034).
REQ-025 BAT clear: key_down=0, key_count=0 on next edge; FIFO untouched; no event.
REQ-026 Latency: final byte strobed in cycle N -> key_down/key_count updated at N+1; ev_valid high at N+1 when FIFO was empty (first-word fall-through).
REQ-027 byte_err in any state except INIT -> IDLE, pending prefix discarded, no event; byte_err wins over simultaneous byte_valid.
REQ-028 In EXT, BRK, EXT_BRK, SKIP: TIMEOUT_CYC cycles without byte_valid -> IDLE; counter restarts on every byte_valid.
REQ-029 FIFO: push and pop same cycle allowed at any occupancy, including full (occupancy unchanged) and empty (push only effective).
REQ-030 Push when full without pop: event dropped, ovf=1 next cycle; key_down still updated.
REQ-031 ovf_clr clears ovf; simultaneous drop and ovf_clr leaves ovf=1.
REQ-032 ev_data undefined-free: holds last head value when ev_valid=0.

Reset
REQ-033 rst low asynchronously forces: state=INIT (WAIT_BAT=1) or IDLE (WAIT_BAT=0), key_down=0, key_count=0, FIFO empty, ev_valid=0, ev_data=0, ovf=0, timeout counter=0; mid-sequence bytes lost; release takes effect on first clk edge with rst high.

Configuration
REQ-034 Macro KEY_REPEAT_EVT_EN defined: make of key already down pushes {1,0,ext,code} (typematic repeat event), key_down/key_count unchanged; undefined: no push, rpt bit constant 0.

Verification
REQ-035 Reset, strobe 1C before AA -> ignored; AA then 1C -> key_down[0x01C]=1, key_count=1, ev_data=11'h01C.
REQ-036 E0 75 then E0 F0 75 -> key_down[0x175] set then cleared, events 11'h175, 11'h375, key_count back 0.
REQ-037 Nine makes (15,1D,24,2D,2C,35,3C,43,44) no pops, FIFO_DEPTH=8 -> 8 events kept, ninth dropped, ovf=1, key_count=9.
REQ-038 Hold 1C: 1C,1C,1C -> one event without macro; three events (2nd/3rd 11'h41C) with KEY_REPEAT_EVT_EN.
REQ-039 F0 then TIMEOUT_CYC idle cycles, then 1C -> treated as make 11'h01C; E1 14 77 E1 F0 14 F0 77 -> no key_down change.
REQ-040 E0 then byte_err, then 75 -> make 11'h075 (not 0x175); keys down then AA -> key_down=0, key_count=0.
